bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-in/serial-out stage upstream of the Moore sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and presents it one bit per clock on `dout`, which drives the detector's `din`. Consecutive words stream with no idle gap. An enable input can stall the bit stream, and a status pulse marks the last bit of each word.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
- IDLE_LEVEL, 0, value driven on `dout` when no word is being sent

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset); release is synchronous to clk
- en  in  1  shift enable; 0 freezes all state (stall)
- load_valid  in  1  producer has a word on load_data
- load_data  in  WIDTH  word to serialize; sampled only on handshake
- load_ready  out  1  combinational; serializer can accept a word this cycle
- dout  out  1  registered serial bit; connects to detector `din`
- dout_valid  out  1  registered; dout carries a word bit this cycle
- word_done  out  1  registered; high while the last bit of a word is on dout
- busy  out  1  registered; 1 in SHIFT state

## Operation
- State machine: IDLE and SHIFT. Internal state: shift register `sreg` [WIDTH], bit counter `cnt` [clog2(WIDTH)].
- Handshake: a word is accepted at an edge where load_valid & load_ready & en are all 1.
- load_ready = reset & en & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)). It is 0 while reset is low or en is low.
- IDLE, on accept:
  - load sreg from load_data
  - dout <= first bit
  - cnt <= 0
  - dout_valid <= 1
  - go to SHIFT
- IDLE, no accept: dout = IDLE_LEVEL, dout_valid = 0.
- SHIFT, en=1, cnt<WIDTH-1:
  - shift sreg toward the output end
  - dout <= next bit
  - cnt <= cnt+1
- SHIFT, en=1, cnt==WIDTH-1 (last bit on dout):
  - if accept, reload exactly as in IDLE and stay in SHIFT (gapless)
  - otherwise dout <= IDLE_LEVEL, dout_valid <= 0, and go to IDLE
- word_done = dout_valid & (cnt==WIDTH-1).
- busy = (state==SHIFT).
- en=0 in any state: no register changes; dout, dout_valid and word_done hold their values; no accept occurs.
- load_data is not required to be stable after the handshake edge.

## Timing
- Reset values (async, immediate on reset=0):
  - state = IDLE, cnt = 0, sreg = 0
  - dout = IDLE_LEVEL
  - dout_valid = 0, word_done = 0, busy = 0
  - load_ready = 0 while reset is low
- Latency: the handshake at edge k puts the first bit on dout in cycle k+1. Bit i of the send order appears in cycle k+1+i when there are no stalls.
- With no stalls a word occupies exactly WIDTH consecutive dout_valid cycles.
- Back-to-back: a handshake on the last-bit cycle makes the next word's first bit follow with zero gap. Throughput is 1 bit/cycle.
- A stall of N cycles extends the current bit by N cycles. The detector downstream then sees that bit repeated; producers must keep en=1 during a word when exact sequences matter.
- Reset mid-word: the word is discarded and dout returns to IDLE_LEVEL immediately. After release, the first accept restarts from bit 0.
- load_valid while busy and not on the last bit: ignored (load_ready=0). The producer holds the word until ready.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, en=1, load 8'b1001_0010 at edge k: dout = 1,0,0,1,0,0,1,0 in cycles k+1..k+8; dout_valid high for exactly 8 cycles; word_done high only in k+8; cycle k+9 has dout=0, dout_valid=0, load_ready=1.
- Back-to-back: hold load_valid=1 with 8'hA5 then 8'h3C: 16 consecutive valid bits 10100101_00111100; load_ready pulses high only in the last-bit cycle of the first word; word_done high in cycles k+8 and k+16.
- LSB_FIRST (MSB_FIRST=0), load 8'b0000_1001: dout = 1,0,0,1,0,0,0,0; feeding a 1001 detector produces exactly one detection.
- Stall: load 8'hF0 and drop en for 3 cycles after the 2nd bit: dout holds 1 for 3 extra cycles; cnt is frozen; the remaining bits 1,1,0,0,0,0 follow; total valid cycles = 11; load_ready=0 during the stall.
- Busy ignore: assert load_valid with 8'hFF in cycle k+3 of a word: no accept; the current word completes unchanged; 8'hFF is accepted in the last-bit cycle.
- Reset mid-word: pull reset low asynchronously (between edges) during bit 4. dout=0, dout_valid=0 and busy=0 take effect immediately, without waiting for an edge. After release, load 8'h81: dout = 1,0,0,0,0,0,0,1 starting at the cycle after the handshake.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word over valid/ready and emits it one bit
// per clock on dout_o, streaming consecutive words with no gap.
module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             word_done_o,
  output logic             busy_o
);

  localparam int unsigned     CntW      = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt   = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] PenultCnt = CntW'(WIDTH - 2);

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic             dout_q;
  logic             dout_valid_q;
  logic             word_done_q;

  logic             on_last;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

  always_comb begin
    on_last      = (state_q == StShift) && (cnt_q == LastCnt);
    load_ready_o = rst_ni & en_i & ((state_q == StIdle) | on_last);
    accept       = load_valid_i & load_ready_o;
    // The output end of sreg is the MSB or LSB depending on send order.
    first_bit    = MSB_FIRST ? load_data_i[WIDTH-1] : load_data_i[0];
    next_bit     = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];
    sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sreg_q       <= '0;
      dout_q       <= IDLE_LEVEL;
      dout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else if (en_i) begin
      if (accept) begin
        // Reload from either state; on the last-bit cycle this gives the gapless handoff.
        state_q      <= StShift;
        sreg_q       <= load_data_i;
        cnt_q        <= '0;
        dout_q       <= first_bit;
        dout_valid_q <= 1'b1;
        word_done_q  <= 1'b0;
      end else if ((state_q == StShift) && !on_last) begin
        sreg_q      <= sreg_shifted;
        dout_q      <= next_bit;
        cnt_q       <= cnt_q + 1'b1;
        word_done_q <= (cnt_q == PenultCnt);
      end else begin
        state_q      <= StIdle;
        dout_q       <= IDLE_LEVEL;
        dout_valid_q <= 1'b0;
        word_done_q  <= 1'b0;
      end
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign word_done_o  = word_done_q;
  assign busy_o       = (state_q == StShift);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: expected bits are queued when a word is driven and
// compared against dout as valid bits appear, for an MSB-first and an LSB-first instance.
module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       lv;
  logic [7:0] ld;

  logic lr_m, dout_m, dv_m, wd_m, busy_m;
  logic lr_l, dout_l, dv_l, wd_l, busy_l;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sel_lsb = 1'b0;
  logic [3:0] hist;
  int   nbits;
  int   det;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .load_valid_i(lv),
    .load_data_i (ld),
    .load_ready_o(lr_m),
    .dout_o      (dout_m),
    .dout_valid_o(dv_m),
    .word_done_o (wd_m),
    .busy_o      (busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .load_valid_i(lv),
    .load_data_i (ld),
    .load_ready_o(lr_l),
    .dout_o      (dout_l),
    .dout_valid_o(dv_l),
    .word_done_o (wd_l),
    .busy_o      (busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w, input bit msb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b    = msb ? w[7-i] : w[i];
      e.last = (i == 7);
      q.push_back(e);
    end
  endtask

  task automatic push_bit(input logic b, input logic last);
    exp_t e;
    e.b    = b;
    e.last = last;
    q.push_back(e);
  endtask

  // One clock: sample #1 after the edge and score the selected instance's output.
  task automatic step();
    logic o_dout, o_dv, o_wd, o_busy;
    exp_t e;
    @(posedge clk);
    #1;
    o_dout = sel_lsb ? dout_l : dout_m;
    o_dv   = sel_lsb ? dv_l : dv_m;
    o_wd   = sel_lsb ? wd_l : wd_m;
    o_busy = sel_lsb ? busy_l : busy_m;
    if (o_dv) begin
      if (q.size() == 0) begin
        chk("dv_extra", o_dv, 1'b0);
      end else begin
        e = q.pop_front();
        chk("dout", o_dout, e.b);
        chk("word_done", o_wd, e.last);
        chk("busy_shift", o_busy, 1'b1);
        hist = {hist[2:0], o_dout};
        nbits++;
        if (nbits >= 4 && hist == 4'b1001) det++;
      end
    end else begin
      chk("dout_idle", o_dout, 1'b0);
      chk("word_done_idle", o_wd, 1'b0);
      chk("busy_idle", o_busy, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    lv    = 1'b1;
    ld    = 8'hFF;
    hist  = '0;
    nbits = 0;
    det   = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", dout_m, 1'b0);
    chk("rst_dv", dv_m, 1'b0);
    chk("rst_wd", wd_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_ready", lr_m, 1'b0);
    step();
    step();
    chk("rst_ready_held", lr_m, 1'b0);
    rst_n = 1'b1;
    lv    = 1'b0;

    // Stalled in idle: no accept even with load_valid high.
    en = 1'b0;
    lv = 1'b1;
    #1 chk("ready_en_low", lr_m, 1'b0);
    step();
    step();
    lv = 1'b0;
    en = 1'b1;

    // Single MSB-first word.
    ld = 8'b1001_0010;
    lv = 1'b1;
    push_word(8'b1001_0010, 1'b1);
    #1 chk("ready_idle_pre", lr_m, 1'b1);
    step();
    lv = 1'b0;
    drain();
    chk("ready_after_word", lr_m, 1'b1);

    // Back-to-back words with load_valid held.
    ld = 8'hA5;
    lv = 1'b1;
    push_word(8'hA5, 1'b1);
    step();
    ld = 8'h3C;
    push_word(8'h3C, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("ready_b2b_mid", lr_m, 1'b0);
      step();
    end
    chk("ready_b2b_last", lr_m, 1'b1);
    step();
    lv = 1'b0;
    drain();

    // LSB-first word into a 1001 detector model.
    sel_lsb = 1'b1;
    hist    = '0;
    nbits   = 0;
    det     = 0;
    ld      = 8'b0000_1001;
    lv      = 1'b1;
    push_word(8'b0000_1001, 1'b0);
    step();
    lv = 1'b0;
    drain();
    chk("det_count", det, 1);
    sel_lsb = 1'b0;

    // Stall for 3 cycles after the second bit.
    ld = 8'hF0;
    lv = 1'b1;
    for (int i = 0; i < 7; i++) push_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push_bit(1'b0, 1'b0);
    push_bit(1'b0, 1'b1);
    step();
    lv = 1'b0;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ready_stall", lr_m, 1'b0);
      step();
    end
    en = 1'b1;
    drain();

    // load_valid while busy is ignored until the last-bit cycle.
    ld = 8'h5A;
    lv = 1'b1;
    push_word(8'h5A, 1'b1);
    step();
    lv = 1'b0;
    step();
    ld = 8'hFF;
    lv = 1'b1;
    push_word(8'hFF, 1'b1);
    for (int i = 0; i < 20 && q.size() > 8; i++) begin
      chk("ready_busy", lr_m, 1'b0);
      step();
    end
    chk("ready_busy_last", lr_m, 1'b1);
    step();
    lv = 1'b0;
    drain();

    // Asynchronous reset during the fourth bit, then a fresh word.
    ld = 8'hF0;
    lv = 1'b1;
    push_word(8'hF0, 1'b1);
    step();
    lv = 1'b0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", dout_m, 1'b0);
    chk("arst_dv", dv_m, 1'b0);
    chk("arst_busy", busy_m, 1'b0);
    chk("arst_wd", wd_m, 1'b0);
    chk("arst_ready", lr_m, 1'b0);
    q.delete();
    step();
    rst_n = 1'b1;
    ld = 8'h81;
    lv = 1'b1;
    push_word(8'h81, 1'b1);
    #1 chk("ready_post_rst", lr_m, 1'b1);
    step();
    lv = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
